// File: rtl/movement_clock_if.sv
// movement_clock_if: control inputs and divided-clock outputs of the movement clock divider.
// The master side drives enable/speed_sel; the slave side (the divider) drives the outputs.
interface movement_clock_if;
  logic       enable;
  logic [1:0] speed_sel;
  logic       movement_clock;
  logic       movement_tick;

  modport master (
    output enable,
    output speed_sel,
    input  movement_clock,
    input  movement_tick
  );

  modport slave (
    input  enable,
    input  speed_sel,
    output movement_clock,
    output movement_tick
  );
endinterface

// File: rtl/movement_clock.sv
// movement_clock: divides vga_clock to the player movement rate, giving a 50% level and a one-cycle tick.
// Define MOVEMENT_CLOCK_FAST_SIM_EN to use SIM_DIVIDE instead of DIVIDE as the period.
module movement_clock #(
  parameter int unsigned DIVIDE     = 100_000,
  parameter int unsigned SIM_DIVIDE = 8
) (
  input logic             vga_clock,
  input logic             reset_n,
  movement_clock_if.slave bus
);

`ifdef MOVEMENT_CLOCK_FAST_SIM_EN
  localparam int unsigned P = SIM_DIVIDE;
`else
  localparam int unsigned P = DIVIDE;
`endif

  localparam int unsigned HALF    = P / 2;
  localparam int unsigned QUARTER = (HALF / 2 < 1) ? 1 : HALF / 2;
  localparam int unsigned CNT_W   = $clog2(P);

  localparam logic [CNT_W-1:0] T_NORMAL = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] T_DOUBLE = CNT_W'(QUARTER - 1);
  localparam logic [CNT_W-1:0] T_HALF   = CNT_W'(2 * HALF - 1);

  generate
    if ((P % 2) != 0 || P < 4) begin : g_bad_period
      $error("movement_clock: period must be even and >= 4");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] terminal;
  logic             level;
  logic             tick;

  always_comb begin
    terminal = T_NORMAL;
    unique case (bus.speed_sel)
      2'b01:   terminal = T_DOUBLE;
      2'b10:   terminal = T_HALF;
      default: terminal = T_NORMAL;
    endcase
  end

  // ">=" rather than "==" so a speed switch that leaves cnt above the new
  // terminal toggles on the next edge instead of running off the end.
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      tick  <= 1'b0;
    end else if (bus.enable) begin
      if (cnt >= terminal) begin
        cnt   <= '0;
        level <= ~level;
        tick  <= ~level;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign bus.movement_clock = level;
  assign bus.movement_tick  = tick;

endmodule

// File: tb/tb_movement_clock.sv
// tb_movement_clock: directed scoreboard bench for movement_clock with an 8-cycle period (HALF=4).
// Stimulus pushes the expected level/tick for each edge; a monitor pops and compares after the edge.
module tb_movement_clock;

  logic vga_clock;
  logic reset_n;

  movement_clock_if bus ();

  movement_clock #(
    .DIVIDE    (8),
    .SIM_DIVIDE(8)
  ) dut (
    .vga_clock(vga_clock),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  typedef struct {
    logic  level;
    logic  tick;
    string name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    vga_clock = 1'b0;
    forever #5 vga_clock = ~vga_clock;
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got level/tick=%b required=%b", name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge vga_clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, {bus.movement_clock, bus.movement_tick}, {e.level, e.tick});
      end
    end
  end

  // Called at a falling edge; bit i of the masks is the expectation after the (i+1)-th rising edge.
  task automatic seq(input logic en, input logic [1:0] spd, input int unsigned n,
                     input logic [31:0] level_bits, input logic [31:0] tick_bits,
                     input string name);
    for (int unsigned i = 0; i < n; i++) begin
      bus.enable    = en;
      bus.speed_sel = spd;
      q.push_back('{level_bits[i], tick_bits[i], $sformatf("%s[%0d]", name, i + 1)});
      @(negedge vga_clock);
    end
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    seq(1'b1, 2'b00, 2, 32'h0, 32'h0, name);
    reset_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got time-out required=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    bus.enable    = 1'b1;
    bus.speed_sel = 2'b00;
    @(negedge vga_clock);

    // reset held with clocks running
    seq(1'b1, 2'b00, 6, 32'h0, 32'h0, "reset_hold");
    reset_n = 1'b1;

    // normal speed: rises at edges 4,12,20, falls at 8,16,24
    seq(1'b1, 2'b00, 24, 32'h0078_7878, 32'h0008_0808, "speed00");

    // double speed: toggles every 2 edges
    do_reset("rst_a");
    seq(1'b1, 2'b01, 8, 32'h0000_0066, 32'h0000_0022, "speed01");

    // half speed: toggles every 8 edges
    do_reset("rst_b");
    seq(1'b1, 2'b10, 24, 32'h0080_7F80, 32'h0080_0080, "speed10");

    // speed 11 behaves as normal
    do_reset("rst_c");
    seq(1'b1, 2'b11, 8, 32'h0000_0078, 32'h0000_0008, "speed11");

    // freeze mid-high-phase (cnt=2), then resume: two more edges to the fall
    do_reset("rst_d");
    seq(1'b1, 2'b00, 6,  32'h0000_0038, 32'h0000_0008, "pre_freeze");
    seq(1'b0, 2'b00, 10, 32'h0000_03FF, 32'h0000_0000, "frozen");
    seq(1'b1, 2'b00, 6,  32'h0000_0021, 32'h0000_0020, "resume");

    // cnt=3 at half speed, switch to double speed: toggle on the next edge
    do_reset("rst_e");
    seq(1'b1, 2'b10, 3, 32'h0, 32'h0, "slow_cnt3");
    seq(1'b1, 2'b01, 6, 32'h0000_0033, 32'h0000_0011, "switch01");

    // asynchronous reset between edges while level is high
    #1;
    check("level_high_before_async_rst", {bus.movement_clock, 1'b0}, 2'b10);
    reset_n = 1'b0;
    #1;
    check("async_rst_drop", {bus.movement_clock, bus.movement_tick}, 2'b00);
    @(negedge vga_clock);
    seq(1'b1, 2'b00, 2, 32'h0, 32'h0, "async_rst_hold");
    reset_n = 1'b1;
    seq(1'b1, 2'b00, 5, 32'h0000_0018, 32'h0000_0008, "after_async_rst");

    @(posedge vga_clock);
    #2;
    check("scoreboard_drained", 2'(q.size() > 0 ? 1 : 0), 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
